// File: rtl/givens_matrix_store_pkg.sv
// Shared command/state types and default Q-format for the Givens matrix store.
// Imported by the store top and its RAM.
package givens_matrix_store_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_BUILD = 2'd2,
    OP_CLEAR = 2'd3
  } givens_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_FRAC_W = 16;

endpackage

// File: rtl/givens_matrix_store_bram_sp.sv
// Inferred single-port RAM with read-first data path and an optional
// output register stage, matching a registered-output block RAM.
module givens_bram_sp
  import givens_matrix_store_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q1;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q1 <= mem[addr];
  end

  if (READ_LAT > 1) begin : g_oreg
    logic [DATA_W-1:0] q2;
    always_ff @(posedge clk) q2 <= q1;
    assign rdata = q2;
  end else begin : g_noreg
    assign rdata = q1;
  end

endmodule

// File: rtl/givens_matrix_store.sv
// DIM x DIM Givens rotation matrix held in a single-port RAM, with a
// self-sequencing fill engine (BUILD/CLEAR), word writes and pipelined reads.
module givens_matrix_store
  import givens_matrix_store_pkg::*;
#(
  parameter int DIM      = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int READ_LAT = 2,
  localparam int DEPTH   = DIM * DIM,
  localparam int AW      = $clog2(DEPTH),
  localparam int IW      = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [IW-1:0]     rot_p,
  input  logic [IW-1:0]     rot_q,
  input  logic [DATA_W-1:0] rot_cos,
  input  logic [DATA_W-1:0] rot_sin,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DATA_W-1:0] ONE_FX  = DATA_W'(1) << FRAC_W;
  localparam logic [AW-1:0]     LAST    = AW'(DEPTH - 1);
  localparam logic [IW-1:0]     LAST_IX = IW'(DIM - 1);
  localparam logic [AW:0]       DEPTH_W = (AW+1)'(DEPTH);

  fill_state_e       state, state_nxt;
  givens_op_e        op;
  logic              accept, last, in_range;
  logic              wr_acc, rd_acc, fill_acc, bad;
  logic              fill_build, ram_we;
  logic [IW-1:0]     p, q, row, col;
  logic [AW-1:0]     cnt, ram_addr;
  logic [DATA_W-1:0] cos_q, sin_q, fill_word;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic [READ_LAT-1:0] vpipe, opipe;

  assign op       = givens_op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;
  assign last     = cnt == LAST;
  assign in_range = {1'b0, cmd_addr} < DEPTH_W;

  assign wr_acc   = accept && op == OP_WRITE;
  assign rd_acc   = accept && op == OP_READ;
  assign fill_acc = accept && (op == OP_CLEAR ||
                    (op == OP_BUILD && rot_p != rot_q));
  assign bad      = accept && ((op == OP_BUILD && rot_p == rot_q) ||
                    ((wr_acc || rd_acc) && !in_range));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (fill_acc) state_nxt = ST_FILL;
      ST_FILL: if (last)     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = state == ST_IDLE;
    busy      = state == ST_FILL;
  end

  // row/col walk alongside cnt so no divider is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      row        <= '0;
      col        <= '0;
      fill_build <= 1'b0;
      p          <= '0;
      q          <= '0;
      cos_q      <= '0;
      sin_q      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= busy && last;
      err  <= bad;
      if (fill_acc) begin
        cnt        <= '0;
        row        <= '0;
        col        <= '0;
        fill_build <= op == OP_BUILD;
        p          <= rot_p;
        q          <= rot_q;
        cos_q      <= rot_cos;
        sin_q      <= rot_sin;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (col == LAST_IX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    fill_word = (row == col) ? ONE_FX : '0;
    if (fill_build) begin
      unique case (1'b1)
        (row == p && col == p),
        (row == q && col == q): fill_word = cos_q;
        (row == p && col == q): fill_word = -sin_q;
        (row == q && col == p): fill_word = sin_q;
        default: ;
      endcase
    end
  end

  assign ram_we    = busy || (wr_acc && in_range);
  assign ram_addr  = busy ? cnt : cmd_addr;
  assign ram_wdata = busy ? fill_word : cmd_wdata;

  givens_bram_sp #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // opipe marks out-of-range reads so their data is forced to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
      opipe <= '0;
    end else begin
      vpipe <= (vpipe << 1) | READ_LAT'(rd_acc);
      opipe <= (opipe << 1) | READ_LAT'(rd_acc && !in_range);
    end
  end

  assign rd_valid = vpipe[READ_LAT-1];
  assign rd_data  = (rd_valid && !opipe[READ_LAT-1]) ? ram_q : '0;

endmodule

// File: tb/tb_givens_matrix_store.sv
// Bench for givens_matrix_store: a DIM=4/READ_LAT=2 and a DIM=3/READ_LAT=1
// instance share command inputs; each has its own cmd_valid.
module tb_givens_matrix_store;

  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] CS  = 32'h0000_B505;
  localparam logic [31:0] NS  = 32'hFFFF_4AFB;
  localparam int          KEY = 1000000;

  typedef struct {
    int          d;
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cv [2];
  logic [1:0]  cmd_op, rot_p, rot_q;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata, rot_cos, rot_sin;
  logic        rdy [2], rv [2], bsy [2], dn [2], er [2];
  logic [31:0] rdd [2];

  int dim [2] = '{4, 3};
  int lat [2] = '{2, 1};
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_until [2] = '{0, 0};
  logic [31:0] mdl [2][16];
  logic [31:0] last_rd [2];
  logic [31:0] exp_rd [int];
  bit          exp_err [int];
  bit          exp_done [int];

  givens_matrix_store #(
    .DIM(4), .DATA_W(32), .FRAC_W(16), .READ_LAT(2)
  ) dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv[0]), .cmd_ready(rdy[0]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rot_p(rot_p), .rot_q(rot_q),
    .rot_cos(rot_cos), .rot_sin(rot_sin),
    .rd_valid(rv[0]), .rd_data(rdd[0]),
    .busy(bsy[0]), .done(dn[0]), .err(er[0])
  );

  givens_matrix_store #(
    .DIM(3), .DATA_W(32), .FRAC_W(16), .READ_LAT(1)
  ) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv[1]), .cmd_ready(rdy[1]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rot_p(rot_p), .rot_q(rot_q),
    .rot_cos(rot_cos), .rot_sin(rot_sin),
    .rd_valid(rv[1]), .rd_data(rdd[1]),
    .busy(bsy[1]), .done(dn[1]), .err(er[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Whole matrix as the rotation rules define it, written at once.
  function automatic void fill_model(int i, bit build);
    int n;
    logic [31:0] v;
    n = dim[i];
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        v = (r == c) ? ONE : 32'h0;
        if (build) begin
          if ((r == rot_p && c == rot_p) || (r == rot_q && c == rot_q))
            v = rot_cos;
          else if (r == rot_p && c == rot_q)
            v = -rot_sin;
          else if (r == rot_q && c == rot_p)
            v = rot_sin;
        end
        mdl[i][r*n+c] = v;
      end
    end
  endfunction

  task automatic on_accept(int i);
    int n, key;
    n   = dim[i] * dim[i];
    key = i * KEY + cyc;
    case (cmd_op)
      2'd0: begin
        if (cmd_addr < n) mdl[i][cmd_addr] = cmd_wdata;
        else exp_err[key+1] = 1'b1;
      end
      2'd1: begin
        if (cmd_addr < n) exp_rd[key+lat[i]] = mdl[i][cmd_addr];
        else begin
          exp_rd[key+lat[i]] = 32'h0;
          exp_err[key+1] = 1'b1;
        end
      end
      2'd2: begin
        if (rot_p == rot_q) exp_err[key+1] = 1'b1;
        else begin
          fill_model(i, 1'b1);
          exp_done[key+1+n] = 1'b1;
          busy_until[i] = cyc + 1 + n;
        end
      end
      default: begin
        fill_model(i, 1'b0);
        exp_done[key+1+n] = 1'b1;
        busy_until[i] = cyc + 1 + n;
      end
    endcase
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        chk($sformatf("reset_flags%0d", i),
            {rdy[i], bsy[i], rv[i], dn[i], er[i]}, 32'b10000);
        chk($sformatf("reset_rd_data%0d", i), rdd[i], 32'h0);
      end else begin
        int  key;
        bit  ev;
        key = i * KEY + cyc;
        ev  = exp_rd.exists(key);
        chk($sformatf("cmd_ready%0d", i), rdy[i], cyc >= busy_until[i]);
        chk($sformatf("busy%0d", i), bsy[i], cyc < busy_until[i]);
        chk($sformatf("rd_valid%0d", i), rv[i], ev);
        if (ev) begin
          chk($sformatf("rd_data%0d", i), rdd[i], exp_rd[key]);
          if (rv[i]) last_rd[i] = rdd[i];
        end
        chk($sformatf("err%0d", i), er[i], exp_err.exists(key));
        chk($sformatf("done%0d", i), dn[i], exp_done.exists(key));
        if (cv[i] && rdy[i]) on_accept(i);
      end
    end
    if (rst) begin
      exp_rd.delete();
      exp_err.delete();
      exp_done.delete();
      busy_until = '{0, 0};
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic issue(int d, logic [1:0] op, logic [3:0] a,
                       logic [31:0] wd, logic [1:0] p, logic [1:0] q,
                       logic [31:0] c, logic [31:0] s);
    cmd_op = op; cmd_addr = a; cmd_wdata = wd;
    rot_p = p; rot_q = q; rot_cos = c; rot_sin = s;
    cv[d] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rdy[d] && !rst) break;
      if (t == 199) begin
        checks++; errors++;
        $display("FAIL accept_timeout dut%0d: got no ready want ready", d);
      end
    end
    @(posedge clk); #1;
    cv[d] = 1'b0;
  endtask

  task automatic rd(int d, int a);
    issue(d, 2'd1, 4'(a), 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic wait_idle(int d);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rdy[d] && cyc >= busy_until[d]) break;
      if (t == 99) begin
        checks++; errors++;
        $display("FAIL idle_timeout dut%0d: got busy want idle", d);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic read_check(int d, int a, logic [31:0] exp);
    last_rd[d] = ~exp;
    rd(d, a);
    repeat (lat[d]) @(negedge clk);
    #1;
    chk($sformatf("readback dut%0d addr%0d", d, a), last_rd[d], exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rd_vec_t     tab [$];
    logic [31:0] b4 [16];
    logic [31:0] b3 [10];
    int          d, r;
    logic [1:0]  op;
    logic [31:0] s;

    b4 = '{ONE, 0, 0, 0, 0, CS, 0, NS, 0, 0, ONE, 0, 0, CS, 0, CS};
    b3 = '{CS, 0, NS, 0, ONE, 0, CS, 0, CS, 0};
    for (int a = 0; a < 16; a++) tab.push_back('{0, 4'(a), b4[a]});
    for (int a = 0; a < 10; a++) tab.push_back('{1, 4'(a), b3[a]});

    cv[0] = 1'b0; cv[1] = 1'b0;
    cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    rot_p = '0; rot_q = '0; rot_cos = '0; rot_sin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(0, 2'd3, 4'd0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    issue(1, 2'd3, 4'd0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    wait_idle(0);
    wait_idle(1);
    for (int a = 0; a < 16; a++)
      read_check(0, a, (a % 5 == 0) ? ONE : 32'h0);
    for (int a = 0; a < 9; a++)
      read_check(1, a, (a % 4 == 0) ? ONE : 32'h0);

    issue(0, 2'd2, 4'd0, 32'h0, 2'd1, 2'd3, CS, CS);
    issue(1, 2'd2, 4'd0, 32'h0, 2'd0, 2'd2, CS, CS);
    wait_idle(0);
    wait_idle(1);
    foreach (tab[k]) read_check(tab[k].d, tab[k].addr, tab[k].exp);

    issue(0, 2'd3, 4'd0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    wait_idle(0);
    issue(0, 2'd2, 4'd0, 32'h0, 2'd2, 2'd2, CS, CS);
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++) rd(0, a);
    read_check(0, 10, ONE);

    for (int a = 0; a < 4; a++) rd(0, a);
    issue(0, 2'd0, 4'd3, 32'h1234_5678, 2'd0, 2'd0, 32'h0, 32'h0);
    read_check(0, 3, 32'h1234_5678);

    issue(0, 2'd2, 4'd0, 32'h0, 2'd0, 2'd1, CS, 32'h8000_0000);
    read_check(0, 1, 32'h8000_0000);
    read_check(0, 4, 32'h8000_0000);

    issue(0, 2'd2, 4'd0, 32'h0, 2'd0, 2'd3, CS, CS);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_flags", {rdy[0], bsy[0], rv[0], dn[0], er[0]},
        32'b10000);
    chk("async_reset_rd_data", rdd[0], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 2'd3, 4'd0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    wait_idle(0);
    read_check(0, 12, 32'h0);

    for (int n = 0; n < 400; n++) begin
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 15));
      op = (r < 7) ? 2'd0 : (r < 13) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      s  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      issue(d, op, 4'($urandom_range(0, 15)), $urandom,
            2'($urandom_range(0, dim[d] - 1)),
            2'($urandom_range(0, dim[d] - 1)), $urandom, s);
    end
    wait_idle(0);
    wait_idle(1);
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
